// File: rtl/ser_pkg.sv
// Shared constants and types for the 10-bit code-group serializer.
// Imported by ser_10b_tx and its testbench.
package ser_pkg;

    localparam int SYM_W_DEF = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // K28.5 comma in both running disparities, as dataout[9:0] (bit 0 sent first).
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

endpackage

// File: rtl/ser_10b_tx.sv
// Parallel-to-serial stage after the 8b/10b encoder: one code group per handshake, LSB first, gapless.
// Optional word_start strobe output is built when SER_WORD_STROBE_EN is defined.
module ser_10b_tx
    import ser_pkg::*;
#(
    parameter int   SYM_W    = SYM_W_DEF,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             underflow
`ifdef SER_WORD_STROBE_EN
    ,
    output logic             word_start
`endif
);

    localparam int               CNT_W    = $clog2(SYM_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SYM_W-1:0] r_shreg;
    logic [SYM_W-1:0] w_shreg_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ser_out;
    logic             w_ser_out_nxt;
    logic             r_ser_active;
    logic             w_ser_active_nxt;
    logic             r_underflow;
    logic             w_underflow_nxt;
    logic             w_last;
    logic             w_xfer;

    // Ready on the last bit of a group is what makes back-to-back groups gapless.
    assign w_last    = (r_cnt == CNT_LAST);
    assign sym_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_last);
    assign w_xfer    = sym_valid && sym_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt      = r_state;
        w_shreg_nxt      = r_shreg;
        w_cnt_nxt        = r_cnt;
        w_ser_out_nxt    = IDLE_LVL;
        w_ser_active_nxt = 1'b0;
        w_underflow_nxt  = 1'b0;

        if (w_xfer) begin
            w_state_nxt      = SHIFT;
            w_shreg_nxt      = sym_in;
            w_cnt_nxt        = '0;
            w_ser_out_nxt    = sym_in[0];
            w_ser_active_nxt = 1'b1;
        end else if (r_state == SHIFT) begin
            if (w_last) begin
                w_state_nxt     = IDLE;
                w_cnt_nxt       = '0;
                w_underflow_nxt = 1'b1;
            end else begin
                // The register shifts right, so the next bit to send is always at index 1.
                w_shreg_nxt      = r_shreg >> 1;
                w_cnt_nxt        = r_cnt + CNT_W'(1);
                w_ser_out_nxt    = r_shreg[1];
                w_ser_active_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shift register is reset too, so no stale group survives a mid-word reset.
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_ser_out    <= IDLE_LVL;
            r_ser_active <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ser_out    <= w_ser_out_nxt;
            r_ser_active <= w_ser_active_nxt;
            r_underflow  <= w_underflow_nxt;
        end
    end

    assign ser_out    = r_ser_out;
    assign ser_active = r_ser_active;
    assign underflow  = r_underflow;

`ifdef SER_WORD_STROBE_EN
    logic r_word_start;

    // Every transfer puts bit 0 of the new group on the line in the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_start <= 1'b0;
        end else begin
            r_word_start <= w_xfer;
        end
    end

    assign word_start = r_word_start;
`endif

endmodule

// File: tb/tb_ser_10b_tx.sv
// Self-checking bench for ser_10b_tx: a bit-queue reference model plus directed K28.5 scenarios.
// Define SER_WORD_STROBE_EN to also exercise the word_start strobe.
module tb_ser_10b_tx;
    import ser_pkg::*;

    localparam int   W        = SYM_W_DEF;
    localparam logic IDLE_LVL = 1'b0;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sym_in;
    logic         sym_valid;
    logic         sym_ready;
    logic         ser_out;
    logic         ser_active;
    logic         underflow;
`ifdef SER_WORD_STROBE_EN
    logic         word_start;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: bits still waiting to reach the line, oldest first.
    bit   mdl_q[$];
    logic exp_ser, exp_act, exp_unf, exp_ready, exp_ws;
    logic [4:0] exp_vec, obs_vec;
    logic last_xfer;
    logic ready_pre;

    always #5 clk = ~clk;

    ser_10b_tx #(
        .SYM_W    (W),
        .IDLE_LVL (IDLE_LVL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .ser_out    (ser_out),
        .ser_active (ser_active),
        .underflow  (underflow)
`ifdef SER_WORD_STROBE_EN
        ,
        .word_start (word_start)
`endif
    );

    task automatic model_reset();
        mdl_q.delete();
        exp_ser   = IDLE_LVL;
        exp_act   = 1'b0;
        exp_unf   = 1'b0;
        exp_ready = 1'b1;
        exp_ws    = 1'b0;
    endtask

    task automatic sample();
`ifdef SER_WORD_STROBE_EN
        obs_vec = {ser_out, ser_active, underflow, sym_ready, word_start};
        exp_vec = {exp_ser, exp_act, exp_unf, exp_ready, exp_ws};
`else
        obs_vec = {ser_out, ser_active, underflow, sym_ready, 1'b0};
        exp_vec = {exp_ser, exp_act, exp_unf, exp_ready, 1'b0};
`endif
    endtask

    // Drive one cycle, advance the model across the edge, sample 1 time unit after it.
    task automatic cycle(input logic v, input logic [W-1:0] d);
        logic prev_act;
        sym_valid = v;
        sym_in    = d;
        #1;
        ready_pre = sym_ready;
        @(posedge clk);
        last_xfer = v && (mdl_q.size() == 0);
        if (last_xfer)
            for (int k = 0; k < W; k++) mdl_q.push_back(d[k]);
        prev_act = exp_act;
        if (mdl_q.size() > 0) begin
            exp_ser = mdl_q.pop_front();
            exp_act = 1'b1;
        end else begin
            exp_ser = IDLE_LVL;
            exp_act = 1'b0;
        end
        exp_unf   = prev_act && !exp_act;
        exp_ws    = last_xfer;
        exp_ready = (mdl_q.size() == 0);
        #1;
        sample();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_in    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ser_out, ser_active, underflow, sym_ready} !== {IDLE_LVL, 3'b001}) begin
            errors++;
            $display("FAIL reset_values: got out/act/unf/rdy=%b want %b",
                     {ser_out, ser_active, underflow, sym_ready}, {IDLE_LVL, 3'b001});
        end
        rst = 1'b0;
        cycle(1'b1, K28_5_RDP);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_pre cycle %0d: got %b want %b", i, obs_vec, exp_vec);
            end
            cycle(1'b0, '0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ser_out, ser_active, underflow, sym_ready} !== {IDLE_LVL, 3'b001}) begin
            errors++;
            $display("FAIL reset_async: got out/act/unf/rdy=%b want %b",
                     {ser_out, ser_active, underflow, sym_ready}, {IDLE_LVL, 3'b001});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_k28();
        logic [W-1:0] got;
        int n_act = 0, n_unf = 0;
        got = '0;
        for (int i = 0; i < 13; i++) begin
            cycle(i == 0, K28_5_RDN);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL single cycle %0d: got %b want %b", i, obs_vec, exp_vec);
            end
            if (i < W) got[i] = ser_out;
            n_act += int'(ser_active);
            n_unf += int'(underflow);
        end
        checks++;
        if (got !== K28_5_RDN) begin
            errors++;
            $display("FAIL single_bits: got %b want %b (bit 0 rightmost)", got, K28_5_RDN);
        end
        checks++;
        if (n_act != W || n_unf != 1) begin
            errors++;
            $display("FAIL single_counts: got active=%0d underflow=%0d want %0d and 1", n_act, n_unf, W);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] got;
        int n_act = 0, n_unf = 0, n_rdy = 0;
        got = '0;
        for (int i = 0; i < 22; i++) begin
            cycle(i <= W, (i == 0) ? K28_5_RDN : K28_5_RDP);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL b2b cycle %0d: got %b want %b", i, obs_vec, exp_vec);
            end
            if (i < 2 * W) begin
                got[i] = ser_out;
                n_unf += int'(underflow);
                n_rdy += int'(ready_pre);
            end
            n_act += int'(ser_active);
            if (i == 2 * W) begin
                checks++;
                if (underflow !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_underflow_end: got %b want 1", underflow);
                end
            end
        end
        checks++;
        if (got !== {K28_5_RDP, K28_5_RDN}) begin
            errors++;
            $display("FAIL b2b_bits: got %b want %b", got, {K28_5_RDP, K28_5_RDN});
        end
        checks++;
        if (n_act != 2 * W || n_unf != 0 || n_rdy != 2) begin
            errors++;
            $display("FAIL b2b_counts: got active=%0d underflow=%0d ready_edges=%0d want 20 0 2",
                     n_act, n_unf, n_rdy);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] grp, got;
        grp = W'($urandom);
        got = '0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0)                cycle(1'b1, grp);
            else if (i >= 4 && i <= 9) cycle(1'b1, 10'h3FF);
            else                       cycle(1'b0, 10'h3FF);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL stall cycle %0d: got %b want %b", i, obs_vec, exp_vec);
            end
            if (i < W) got[i] = ser_out;
        end
        checks++;
        if (got !== grp) begin
            errors++;
            $display("FAIL stall_bits: got %b want %b", got, grp);
        end
    endtask

    task automatic test_reset_midword();
        logic [W-1:0] got;
        int n_unf = 0;
        got = '0;
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0, K28_5_RDN);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL rst_mid pre cycle %0d: got %b want %b", i, obs_vec, exp_vec);
            end
            n_unf += int'(underflow);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({ser_out, ser_active, underflow, sym_ready} !== {IDLE_LVL, 3'b001}) begin
            errors++;
            $display("FAIL rst_mid_async: got out/act/unf/rdy=%b want %b",
                     {ser_out, ser_active, underflow, sym_ready}, {IDLE_LVL, 3'b001});
        end
        @(posedge clk);
        #1;
        n_unf += int'(underflow);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            cycle(i == 0, K28_5_RDP);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL rst_mid post cycle %0d: got %b want %b", i, obs_vec, exp_vec);
            end
            if (i < W) begin
                got[i] = ser_out;
                n_unf += int'(underflow);
            end
        end
        checks++;
        if (got !== K28_5_RDP || n_unf != 0) begin
            errors++;
            $display("FAIL rst_mid_result: got bits=%b underflow=%0d want %b and 0", got, n_unf, K28_5_RDP);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, W'($urandom));
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < W + 2; i++) begin
            cycle(1'b0, '0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_drain cycle %0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
    endtask

`ifdef SER_WORD_STROBE_EN
    task automatic test_word_start();
        logic want;
        for (int i = 0; i < 24; i++) begin
            cycle(i <= 2 * W, W'($urandom));
            want = (i == 0) || (i == W) || (i == 2 * W);
            checks++;
            if (word_start !== want) begin
                errors++;
                $display("FAIL word_start cycle %0d: got %b want %b", i + 1, word_start, want);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_k28();
        test_back_to_back();
        test_stall();
        test_reset_midword();
        test_random();
`ifdef SER_WORD_STROBE_EN
        test_word_start();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
